hpdcache_sram_scrub_ctrl: RTL and testbench

//  Front-end controller for one ECC-protected 1RW byte-enable SRAM instance.

---
 rtl/hpdcache_sram_scrub_ctrl_if.sv | 51 +++++
 rtl/hpdcache_sram_scrub_ctrl.sv | 154 +++++++++++++++
 tb/tb_hpdcache_sram_scrub_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_sram_scrub_ctrl_if.sv
// Request, response, SRAM and status signals of the SRAM scrub controller.
// The controller takes the slave modport; the environment driving it takes master.
interface hpdcache_sram_scrub_ctrl_if #(
   parameter int unsigned ADDR_SIZE = 6,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned NDATA     = 1,
   parameter int unsigned CNT_WIDTH = 16
);
   localparam int unsigned W  = NDATA * DATA_SIZE;
   localparam int unsigned BE = W / 8;

   logic                 scrub_en_i;
   logic                 clr_i;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 req_we_i;
   logic [ADDR_SIZE-1:0] req_addr_i;
   logic [W-1:0]         req_wdata_i;
   logic [BE-1:0]        req_wbe_i;
   logic                 rsp_valid_o;
   logic [W-1:0]         rsp_rdata_o;
   logic [NDATA-1:0]     rsp_err_unc_o;
   logic                 sram_cs_o;
   logic                 sram_we_o;
   logic [ADDR_SIZE-1:0] sram_addr_o;
   logic [W-1:0]         sram_wdata_o;
   logic [BE-1:0]        sram_wbyteenable_o;
   logic [W-1:0]         sram_rdata_i;
   logic [NDATA-1:0]     sram_err_cor_i;
   logic [NDATA-1:0]     sram_err_unc_i;
   logic [CNT_WIDTH-1:0] cor_cnt_o;
   logic [CNT_WIDTH-1:0] unc_cnt_o;
   logic                 unc_valid_o;
   logic [ADDR_SIZE-1:0] unc_addr_o;

   modport slave (
      input  scrub_en_i, clr_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wbe_i,
             sram_rdata_i, sram_err_cor_i, sram_err_unc_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_unc_o,
             sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wbyteenable_o,
             cor_cnt_o, unc_cnt_o, unc_valid_o, unc_addr_o
   );

   modport master (
      output scrub_en_i, clr_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wbe_i,
             sram_rdata_i, sram_err_cor_i, sram_err_unc_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_unc_o,
             sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wbyteenable_o,
             cor_cnt_o, unc_cnt_o, unc_valid_o, unc_addr_o
   );
endinterface

// File: rtl/hpdcache_sram_scrub_ctrl.sv
// ECC SRAM front end: functional 1RW access arbitrated against a periodic scrub/writeback.
// Reads respond one cycle after accept; req_ready drops during scrub and when a scrub turns urgent.
module hpdcache_sram_scrub_ctrl #(
   parameter int unsigned ADDR_SIZE    = 6,
   parameter int unsigned DATA_SIZE    = 64,
   parameter int unsigned DEPTH        = 2**ADDR_SIZE,
   parameter int unsigned NDATA        = 1,
   parameter int unsigned SCRUB_PERIOD = 1024,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input logic                        clk,
   input logic                        rst,
   hpdcache_sram_scrub_ctrl_if.slave  bus
);
   localparam int unsigned W  = NDATA * DATA_SIZE;
   localparam int unsigned BE = W / 8;
   localparam int unsigned TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
   localparam logic [TW-1:0]        RELOAD   = TW'(SCRUB_PERIOD - 1);
   localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RD_CHK, WB} state_t;

   state_t               state, state_n;
   logic [TW-1:0]        timer;
   logic                 pending, urgent, pending_n, urgent_n;
   logic                 ready_q, func_rd_q;
   logic [ADDR_SIZE-1:0] scrub_addr, rd_addr_q;
   logic [W-1:0]         wb_data_q;
   logic [CNT_WIDTH-1:0] cor_cnt, unc_cnt;
   logic                 unc_valid;
   logic [ADDR_SIZE-1:0] unc_addr;

   logic                 expire, scrub_go, accept, null_wr;
   logic                 any_cor, any_unc, rd_present, cor_hit, unc_hit;
   logic                 go_wb, scrub_done;
   logic                 sram_cs, sram_we;
   logic [ADDR_SIZE-1:0] sram_addr;
   logic [W-1:0]         sram_wdata;
   logic [BE-1:0]        sram_wbe;

   assign expire     = bus.scrub_en_i && (timer == '0);
   assign scrub_go   = (state == IDLE) && pending && bus.scrub_en_i && (!bus.req_valid_i || urgent);
   assign accept     = (state == IDLE) && bus.req_valid_i && ready_q && !scrub_go;
   // An all-zero-byte-enable write is accepted but never reaches the SRAM.
   assign null_wr    = bus.req_we_i && (bus.req_wbe_i == '0);
   assign any_cor    = |bus.sram_err_cor_i;
   assign any_unc    = |bus.sram_err_unc_i;
   assign rd_present = func_rd_q || (state == RD_CHK);
   assign cor_hit    = rd_present && any_cor && !any_unc;
   assign unc_hit    = rd_present && any_unc;
   assign go_wb      = (state == RD_CHK) && any_cor && !any_unc;
   assign scrub_done = ((state == RD_CHK) && !go_wb) || (state == WB);

   always_comb begin
      state_n   = state;
      pending_n = 1'b0;
      urgent_n  = 1'b0;
      case (state)
         IDLE:    if (scrub_go) state_n = RD_CHK;
         RD_CHK:  state_n = go_wb ? WB : IDLE;
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // A fresh expiry re-arms pending even on the completion cycle.
      if (bus.scrub_en_i) begin
         pending_n = (pending && !scrub_done) || expire;
         urgent_n  = (urgent || (expire && pending)) && !scrub_done;
      end
   end

   always_comb begin
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      sram_wbe   = '0;
      if (state == WB) begin
         sram_cs    = 1'b1;
         sram_we    = 1'b1;
         sram_addr  = scrub_addr;
         sram_wdata = wb_data_q;
         sram_wbe   = '1;
      end else if (scrub_go) begin
         sram_cs    = 1'b1;
         sram_addr  = scrub_addr;
      end else if (accept && !null_wr) begin
         sram_cs    = 1'b1;
         sram_we    = bus.req_we_i;
         sram_addr  = bus.req_addr_i;
         sram_wdata = bus.req_wdata_i;
         sram_wbe   = bus.req_wbe_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= RELOAD;
         pending    <= 1'b0;
         urgent     <= 1'b0;
         ready_q    <= 1'b0;
         func_rd_q  <= 1'b0;
         scrub_addr <= '0;
         rd_addr_q  <= '0;
         wb_data_q  <= '0;
         cor_cnt    <= '0;
         unc_cnt    <= '0;
         unc_valid  <= 1'b0;
         unc_addr   <= '0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         urgent    <= urgent_n;
         ready_q   <= (state_n == IDLE) && !(pending_n && urgent_n);
         func_rd_q <= accept && !bus.req_we_i;
         timer     <= (!bus.scrub_en_i || expire) ? RELOAD : timer - TW'(1);
         if (sram_cs && !sram_we)
            rd_addr_q <= sram_addr;
         if (state == RD_CHK)
            wb_data_q <= bus.sram_rdata_i;
         if (scrub_done)
            scrub_addr <= (scrub_addr == LAST_ROW) ? '0 : scrub_addr + ADDR_SIZE'(1);
         if (bus.clr_i) begin
            cor_cnt   <= '0;
            unc_cnt   <= '0;
            unc_valid <= 1'b0;
            unc_addr  <= '0;
         end else begin
            if (cor_hit && (cor_cnt != '1))
               cor_cnt <= cor_cnt + CNT_WIDTH'(1);
            if (unc_hit && (unc_cnt != '1))
               unc_cnt <= unc_cnt + CNT_WIDTH'(1);
            if (unc_hit && !unc_valid) begin
               unc_valid <= 1'b1;
               unc_addr  <= rd_addr_q;
            end
         end
      end
   end

   assign bus.req_ready_o        = ready_q;
   assign bus.rsp_valid_o        = func_rd_q;
   assign bus.rsp_rdata_o        = func_rd_q ? bus.sram_rdata_i : '0;
   assign bus.rsp_err_unc_o      = func_rd_q ? bus.sram_err_unc_i : '0;
   assign bus.sram_cs_o          = sram_cs;
   assign bus.sram_we_o          = sram_we;
   assign bus.sram_addr_o        = sram_addr;
   assign bus.sram_wdata_o       = sram_wdata;
   assign bus.sram_wbyteenable_o = sram_wbe;
   assign bus.cor_cnt_o          = cor_cnt;
   assign bus.unc_cnt_o          = unc_cnt;
   assign bus.unc_valid_o        = unc_valid;
   assign bus.unc_addr_o         = unc_addr;
endmodule

// File: tb/tb_hpdcache_sram_scrub_ctrl.sv
// Directed bench for hpdcache_sram_scrub_ctrl: vector table for functional traffic,
// hand sequences for scrub timing, writeback, urgency, saturation and reset.
module tb_hpdcache_sram_scrub_ctrl;
   localparam int AS = 6, DS = 32, ND = 1, CW = 2, SP = 8, DEP = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hpdcache_sram_scrub_ctrl_if #(.ADDR_SIZE(AS), .DATA_SIZE(DS), .NDATA(ND), .CNT_WIDTH(CW)) bus ();

   hpdcache_sram_scrub_ctrl #(
      .ADDR_SIZE(AS), .DATA_SIZE(DS), .DEPTH(DEP), .NDATA(ND), .SCRUB_PERIOD(SP), .CNT_WIDTH(CW)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic vld; logic we; logic [5:0] addr; logic [31:0] wdata; logic [3:0] wbe;
      logic [31:0] rdata; logic cor; logic unc;
      logic rdy; logic cs; logic swe; logic [5:0] saddr; logic [31:0] swdata; logic [3:0] swbe;
      logic rvld; logic [31:0] rrdata; logic runc; logic [1:0] ccnt; logic [1:0] ucnt;
   } vec_t;

   vec_t tbl [12];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [43:0] sram_bus();
      return {bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o, bus.sram_wbyteenable_o};
   endfunction

   function automatic logic [33:0] rsp_bus();
      return {bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_unc_o};
   endfunction

   function automatic logic [3:0] cnts();
      return {bus.cor_cnt_o, bus.unc_cnt_o};
   endfunction

   task automatic idle();
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_addr_i     = '0;
      bus.req_wdata_i    = '0;
      bus.req_wbe_i      = '0;
      bus.sram_rdata_i   = '0;
      bus.sram_err_cor_i = '0;
      bus.sram_err_unc_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       inj;
      logic       found;
      int         nrd, nwb, nlow, first_low, nacc, scrub_k, wb_k;
      logic [5:0] rd_a [6];
      int         rd_c [6];
      logic [5:0] exp_rows [6];
      logic [5:0] scrub_a;

      //            vld   we    addr   wdata          wbe    rdata          cor   unc   | rdy  cs    swe   saddr  swdata         swbe   rvld  rrdata         runc  cc     uc
      tbl[0]  = '{1'b1, 1'b0, 6'd5,  32'h0,         4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd0, 2'd0};
      tbl[1]  = '{1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b1, 32'hA5A5_0001, 1'b0, 2'd0, 2'd0};
      tbl[2]  = '{1'b1, 1'b1, 6'd9,  32'h1234_5678, 4'h5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd9,  32'h1234_5678, 4'h5, 1'b0, 32'h0,         1'b0, 2'd0, 2'd0};
      tbl[3]  = '{1'b1, 1'b1, 6'd10, 32'h0000_FFFF, 4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd0, 2'd0};
      tbl[4]  = '{1'b1, 1'b0, 6'd7,  32'h0,         4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd7,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd0, 2'd0};
      tbl[5]  = '{1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b1, 32'h0000_0077, 1'b1, 2'd0, 2'd0};
      tbl[6]  = '{1'b1, 1'b0, 6'd2,  32'h0,         4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd2,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd0, 2'd1};
      tbl[7]  = '{1'b1, 1'b0, 6'd3,  32'h0,         4'h0, 32'h0000_0022, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3,  32'h0,         4'h0, 1'b1, 32'h0000_0022, 1'b1, 2'd0, 2'd1};
      tbl[8]  = '{1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b1, 32'h0000_0033, 1'b0, 2'd0, 2'd2};
      tbl[9]  = '{1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 32'h0000_0044, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd1, 2'd2};
      tbl[10] = '{1'b1, 1'b0, 6'd4,  32'h0,         4'h0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd4,  32'h0,         4'h0, 1'b0, 32'h0,         1'b0, 2'd1, 2'd2};
      tbl[11] = '{1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 32'h0000_0055, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,         4'h0, 1'b1, 32'h0000_0055, 1'b1, 2'd1, 2'd2};
      exp_rows = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd0};

      rst = 1'b0;
      bus.scrub_en_i = 1'b0;
      bus.clr_i      = 1'b0;
      idle();
      #2 rst = 1'b1;
      #1;
      check("reset_sram", 64'(sram_bus()), 64'd0);
      check("reset_rsp", 64'(rsp_bus()), 64'd0);
      check("reset_status", 64'({bus.req_ready_o, cnts(), bus.unc_valid_o, bus.unc_addr_o}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Functional traffic with scrubbing disabled.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.req_valid_i    = tbl[i].vld;
         bus.req_we_i       = tbl[i].we;
         bus.req_addr_i     = tbl[i].addr;
         bus.req_wdata_i    = tbl[i].wdata;
         bus.req_wbe_i      = tbl[i].wbe;
         bus.sram_rdata_i   = tbl[i].rdata;
         bus.sram_err_cor_i = tbl[i].cor;
         bus.sram_err_unc_i = tbl[i].unc;
         #1;
         check($sformatf("vec%0d_sram", i), 64'(sram_bus()),
               64'({tbl[i].cs, tbl[i].swe, tbl[i].saddr, tbl[i].swdata, tbl[i].swbe}));
         check($sformatf("vec%0d_rsp", i), 64'(rsp_bus()), 64'({tbl[i].rvld, tbl[i].rrdata, tbl[i].runc}));
         check($sformatf("vec%0d_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].rdy));
         check($sformatf("vec%0d_cnt", i), 64'(cnts()), 64'({tbl[i].ccnt, tbl[i].ucnt}));
      end
      @(negedge clk);
      idle();
      #1;
      check("post_vec_cnt", 64'(cnts()), 64'({2'd1, 2'd3}));
      check("unc_log_first_row", 64'({bus.unc_valid_o, bus.unc_addr_o}), 64'({1'b1, 6'd7}));

      @(negedge clk);
      bus.clr_i = 1'b1;
      @(negedge clk);
      bus.clr_i = 1'b0;
      #1;
      check("clr_status", 64'({cnts(), bus.unc_valid_o, bus.unc_addr_o}), 64'd0);

      // Idle-bus scrubbing: rows 0..4 then wrap, correctable error on row 3.
      @(negedge clk);
      bus.scrub_en_i = 1'b1;
      nrd = 0;
      nwb = 0;
      inj = 1'b0;
      for (int cyc = 0; cyc < 80 && nrd < 6; cyc++) begin
         @(negedge clk);
         idle();
         if (inj) begin
            bus.sram_rdata_i   = 32'hC0DE_0003;
            bus.sram_err_cor_i = 1'b1;
            inj = 1'b0;
         end
         #1;
         if (bus.sram_cs_o && bus.sram_we_o) begin
            nwb++;
            check("scrub_wb", 64'({bus.req_ready_o, bus.sram_addr_o, bus.sram_wdata_o, bus.sram_wbyteenable_o}),
                  64'({1'b0, 6'd3, 32'hC0DE_0003, 4'hF}));
         end
         if (bus.sram_cs_o && !bus.sram_we_o) begin
            rd_a[nrd] = bus.sram_addr_o;
            rd_c[nrd] = cyc;
            if (bus.sram_addr_o == 6'd3) inj = 1'b1;
            nrd++;
         end
      end
      check("scrub_read_count", 64'(nrd), 64'd6);
      for (int i = 0; i < nrd; i++) begin
         check($sformatf("scrub_row%0d", i), 64'(rd_a[i]), 64'(exp_rows[i]));
         if (i > 0) check($sformatf("scrub_gap%0d", i), 64'(rd_c[i] - rd_c[i-1]), 64'd8);
      end
      check("scrub_wb_count", 64'(nwb), 64'd1);
      @(negedge clk);
      idle();
      bus.scrub_en_i = 1'b0;
      #1;
      check("scrub_cor_cnt", 64'(bus.cor_cnt_o), 64'd1);
      @(negedge clk);

      // Continuous functional reads: scrub waits for urgency, then stalls for read+check+writeback.
      nlow = 0; first_low = -1; nacc = 0; scrub_k = -1; wb_k = -1; scrub_a = '0; inj = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 30; k++) begin
         if (k > 0) @(negedge clk);
         idle();
         bus.scrub_en_i  = 1'b1;
         bus.req_valid_i = 1'b1;
         bus.req_addr_i  = 6'd20;
         if (inj) begin
            bus.sram_rdata_i   = 32'hC0DE_0001;
            bus.sram_err_cor_i = 1'b1;
            inj = 1'b0;
         end
         #1;
         if (!bus.req_ready_o) begin
            if (nlow == 0) first_low = k;
            nlow++;
         end else if (bus.sram_cs_o) begin
            nacc++;
         end
         if (bus.sram_cs_o && !bus.sram_we_o && !bus.req_ready_o) begin
            scrub_k = k;
            scrub_a = bus.sram_addr_o;
            inj = 1'b1;
         end
         if (bus.sram_cs_o && bus.sram_we_o) wb_k = k;
      end
      check("urgent_first_stall", 64'(first_low), 64'd16);
      check("urgent_stall_len", 64'(nlow), 64'd3);
      check("urgent_scrub_cycle", 64'(scrub_k), 64'd16);
      check("urgent_scrub_row", 64'(scrub_a), 64'd1);
      check("urgent_wb_cycle", 64'(wb_k), 64'd18);
      check("urgent_accepts", 64'(nacc), 64'd27);
      @(negedge clk);
      idle();
      bus.scrub_en_i = 1'b0;
      #1;
      check("urgent_cor_cnt", 64'(bus.cor_cnt_o), 64'd2);

      // Saturation and clear-wins.
      @(negedge clk);
      bus.clr_i = 1'b1;
      @(negedge clk);
      bus.clr_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         idle();
         bus.req_valid_i = 1'b1;
         bus.req_addr_i  = 6'(i);
         @(negedge clk);
         idle();
         bus.sram_rdata_i   = 32'(i);
         bus.sram_err_cor_i = 1'b1;
      end
      @(negedge clk);
      idle();
      #1;
      check("sat_cor_cnt", 64'(bus.cor_cnt_o), 64'd3);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      @(negedge clk);
      idle();
      bus.sram_err_cor_i = 1'b1;
      bus.clr_i          = 1'b1;
      @(negedge clk);
      idle();
      bus.clr_i = 1'b0;
      #1;
      check("clr_wins_cor_cnt", 64'(bus.cor_cnt_o), 64'd0);

      // Reset during a writeback of row 2; scrubbing restarts at row 0.
      bus.scrub_en_i = 1'b1;
      found = 1'b0;
      inj   = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         idle();
         if (inj) begin
            bus.sram_rdata_i   = 32'hBEEF_0002;
            bus.sram_err_cor_i = 1'b1;
            inj = 1'b0;
         end
         #1;
         if (bus.sram_cs_o && bus.sram_we_o) begin
            found = 1'b1;
            break;
         end
         if (bus.sram_cs_o) inj = 1'b1;
      end
      check("rstwb_found", 64'(found), 64'd1);
      check("rstwb_wb", 64'(sram_bus()), 64'({1'b1, 1'b1, 6'd2, 32'hBEEF_0002, 4'hF}));
      check("rstwb_cor_cnt", 64'(bus.cor_cnt_o), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("rstwb_sram", 64'(sram_bus()), 64'd0);
      check("rstwb_rsp", 64'(rsp_bus()), 64'd0);
      check("rstwb_status", 64'({bus.req_ready_o, cnts(), bus.unc_valid_o, bus.unc_addr_o}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (bus.sram_cs_o && !bus.sram_we_o) begin
            found = 1'b1;
            check("rst_restart_row", 64'(bus.sram_addr_o), 64'd0);
            break;
         end
      end
      check("rst_restart_found", 64'(found), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
